// File: rtl/fifo_prog_pkg.sv
// Shared types and sizing helpers for the programmable FIFO.
// Imported by fifo_prog and its storage array.
package fifo_prog_pkg;

   typedef enum logic {
      FIFO_STD  = 1'b0,
      FIFO_FWFT = 1'b1
   } fifo_mode_e;

   // Width needed to hold a level from 0 to depth inclusive.
   function automatic int level_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fifo_prog_mem.sv
// Simple dual-port storage for fifo_prog: synchronous write, asynchronous read.
// Holds no reset; stale contents are masked by the pointer and level logic.
module fifo_prog_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Store one word per accepted write.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_prog.sv
// Single-clock FIFO with programmable thresholds, fill level, FWFT or registered
// read, synchronous flush and sticky overflow/underflow flags.
module fifo_prog
   import fifo_prog_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int FWFT     = 0,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2,
   localparam int LW      = level_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             flush,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [LW-1:0]    level,
   output logic             overflow,
   output logic             underflow,
   input  logic             clr_err
);

   localparam int              PW        = ptr_width(DEPTH);
   localparam fifo_mode_e      MODE      = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
   localparam logic [PW-1:0]   LAST_PTR  = PW'(DEPTH - 1);
   localparam logic [LW-1:0]   DEPTH_LVL = LW'(DEPTH);
   localparam logic [LW-1:0]   AF_LVL    = LW'(AF_LEVEL);
   localparam logic [LW-1:0]   AE_LVL    = LW'(AE_LEVEL);

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dv_q, dv_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             wr_acc, rd_acc, mem_we;
   logic [WIDTH-1:0] rdata;

   // Flags depend only on the registered level, never on this cycle's requests.
   assign full         = (level_q == DEPTH_LVL);
   assign empty        = (level_q == {LW{1'b0}});
   assign almost_full  = (level_q >= AF_LVL);
   assign almost_empty = (level_q <= AE_LVL);
   assign level        = level_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

   assign wr_acc = wr_en & ~full;
   assign rd_acc = rd_en & ~empty;
   assign mem_we = wr_acc & ~flush & rstn;

   fifo_prog_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_ptr_q),
      .wdata (din),
      .raddr (rd_ptr_q),
      .rdata (rdata)
   );

   // Next-state for pointers, level, read register and sticky errors.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      dout_d   = dout_q;
      dv_d     = 1'b0;
      if (wr_acc) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? {PW{1'b0}} : wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (rd_acc) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? {PW{1'b0}} : rd_ptr_q + PW'(1);
         dout_d   = rdata;
         dv_d     = 1'b1;
      end else begin
         rd_ptr_d = rd_ptr_q;
         dout_d   = dout_q;
         dv_d     = 1'b0;
      end
      case ({wr_acc, rd_acc})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      // A new error event outranks a coincident clear.
      ovf_d = (wr_en & full)  ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
      unf_d = (rd_en & empty) ? 1'b1 : (clr_err ? 1'b0 : unf_q);
   end

   // State registers; flush clears the datapath but leaves the error flags running.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         level_q  <= {LW{1'b0}};
         dout_q   <= {WIDTH{1'b0}};
         dv_q     <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else if (flush) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         level_q  <= {LW{1'b0}};
         dout_q   <= {WIDTH{1'b0}};
         dv_q     <= 1'b0;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         dout_q   <= dout_d;
         dv_q     <= dv_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   assign dout       = (MODE == FIFO_FWFT) ? (empty ? {WIDTH{1'b0}} : rdata) : dout_q;
   assign dout_valid = (MODE == FIFO_FWFT) ? ~empty : dv_q;

endmodule

// File: tb/tb_fifo_prog.sv
// Directed self-checking bench: a DEPTH=16 registered-read FIFO and a
// DEPTH=5 FWFT FIFO driven through fill, drain, wrap, flush and reset.
module tb_fifo_prog;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic       a_rstn, a_flush, a_wr, a_rd, a_clr;
   logic [7:0] a_din, a_dout;
   logic       a_dv, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
   logic [4:0] a_level;

   logic       b_rstn, b_flush, b_wr, b_rd, b_clr;
   logic [7:0] b_din, b_dout;
   logic       b_dv, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
   logic [2:0] b_level;

   fifo_prog #(.WIDTH(8), .DEPTH(16), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)) dut_a (
      .clk(clk), .rstn(a_rstn), .flush(a_flush), .wr_en(a_wr), .din(a_din),
      .rd_en(a_rd), .dout(a_dout), .dout_valid(a_dv), .full(a_full), .empty(a_empty),
      .almost_full(a_af), .almost_empty(a_ae), .level(a_level),
      .overflow(a_ovf), .underflow(a_unf), .clr_err(a_clr)
   );

   fifo_prog #(.WIDTH(8), .DEPTH(5), .FWFT(1)) dut_b (
      .clk(clk), .rstn(b_rstn), .flush(b_flush), .wr_en(b_wr), .din(b_din),
      .rd_en(b_rd), .dout(b_dout), .dout_valid(b_dv), .full(b_full), .empty(b_empty),
      .almost_full(b_af), .almost_empty(b_ae), .level(b_level),
      .overflow(b_ovf), .underflow(b_unf), .clr_err(b_clr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      a_rstn = 1'b0; a_flush = 1'b0; a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b0; a_din = 8'h00;
      b_rstn = 1'b0; b_flush = 1'b0; b_wr = 1'b0; b_rd = 1'b0; b_clr = 1'b0; b_din = 8'h00;
      tick();
      tick();
      chk("a_rst_level", 32'(a_level), 32'd0);
      chk("a_rst_empty", 32'(a_empty), 32'd1);
      chk("a_rst_full",  32'(a_full),  32'd0);
      chk("a_rst_ae",    32'(a_ae),    32'd1);
      chk("a_rst_af",    32'(a_af),    32'd0);
      chk("a_rst_dout",  32'(a_dout),  32'd0);
      chk("a_rst_dv",    32'(a_dv),    32'd0);
      chk("a_rst_ovf",   32'(a_ovf),   32'd0);
      chk("a_rst_unf",   32'(a_unf),   32'd0);
      chk("b_rst_dout",  32'(b_dout),  32'd0);
      chk("b_rst_dv",    32'(b_dv),    32'd0);
      a_rstn = 1'b1;
      b_rstn = 1'b1;

      // Fill A with 0x01..0x10, watching thresholds at every level.
      for (int k = 1; k <= 16; k++) begin
         a_wr = 1'b1; a_din = 8'(k);
         tick();
         chk("a_fill_level", 32'(a_level), 32'(k));
         chk("a_fill_ae",    32'(a_ae),    32'(k <= 2));
         chk("a_fill_af",    32'(a_af),    32'(k >= 14));
         chk("a_fill_full",  32'(a_full),  32'(k == 16));
      end
      a_din = 8'hEE;
      tick();
      a_wr = 1'b0;
      chk("a_ovf_set",   32'(a_ovf),   32'd1);
      chk("a_ovf_level", 32'(a_level), 32'd16);

      // Drain with registered read: each word one cycle after rd_en.
      a_rd = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         chk("a_rd_dout", 32'(a_dout), 32'(i));
         chk("a_rd_dv",   32'(a_dv),   32'd1);
      end
      a_rd = 1'b0;
      tick();
      chk("a_drain_dv",    32'(a_dv),    32'd0);
      chk("a_drain_empty", 32'(a_empty), 32'd1);
      chk("a_drain_hold",  32'(a_dout),  32'h10);
      chk("a_drain_unf",   32'(a_unf),   32'd0);
      a_rd = 1'b1;
      tick();
      a_rd = 1'b0;
      chk("a_unf_set",  32'(a_unf),  32'd1);
      chk("a_unf_dv",   32'(a_dv),   32'd0);
      chk("a_unf_dout", 32'(a_dout), 32'h10);
      a_clr = 1'b1;
      tick();
      a_clr = 1'b0;
      chk("a_clr_ovf", 32'(a_ovf), 32'd0);
      chk("a_clr_unf", 32'(a_unf), 32'd0);

      // Level 8, then 20 cycles of simultaneous write and read.
      for (int i = 0; i < 8; i++) begin
         a_wr = 1'b1; a_din = 8'(32'h20 + i);
         tick();
      end
      chk("a_pre_sim_level", 32'(a_level), 32'd8);
      a_rd = 1'b1;
      for (int i = 0; i < 20; i++) begin
         a_din = 8'(32'h28 + i);
         tick();
         chk("a_sim_level", 32'(a_level), 32'd8);
         chk("a_sim_dout",  32'(a_dout),  32'(32'h20 + i));
         chk("a_sim_dv",    32'(a_dv),    32'd1);
      end
      a_rd = 1'b0;

      // Refill to full, overflow, read down to 9 and flush.
      for (int i = 0; i < 8; i++) begin
         a_din = 8'(32'h3C + i);
         tick();
      end
      chk("a_refill_full", 32'(a_full), 32'd1);
      a_din = 8'hEE;
      tick();
      a_wr = 1'b0;
      chk("a_ovf2", 32'(a_ovf), 32'd1);
      a_rd = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("a_rd7_dout", 32'(a_dout), 32'(32'h34 + i));
      end
      a_rd = 1'b0;
      chk("a_pre_flush_level", 32'(a_level), 32'd9);
      a_flush = 1'b1;
      tick();
      a_flush = 1'b0;
      chk("a_flush_level", 32'(a_level), 32'd0);
      chk("a_flush_empty", 32'(a_empty), 32'd1);
      chk("a_flush_dv",    32'(a_dv),    32'd0);
      chk("a_flush_dout",  32'(a_dout),  32'd0);
      chk("a_flush_ovf",   32'(a_ovf),   32'd1);

      // Write then read: data on dout after the read edge.
      a_wr = 1'b1; a_din = 8'h55;
      tick();
      a_wr = 1'b0;
      chk("a_lat_level", 32'(a_level), 32'd1);
      a_rd = 1'b1;
      tick();
      a_rd = 1'b0;
      chk("a_lat_dout", 32'(a_dout), 32'h55);
      chk("a_lat_dv",   32'(a_dv),   32'd1);

      // Reset mid-stream discards contents and clears errors.
      for (int i = 0; i < 3; i++) begin
         a_wr = 1'b1; a_din = 8'(32'h61 + i);
         tick();
      end
      a_wr = 1'b0;
      chk("a_mid_level", 32'(a_level), 32'd3);
      a_rstn = 1'b0;
      tick();
      a_rstn = 1'b1;
      chk("a_mrst_level", 32'(a_level), 32'd0);
      chk("a_mrst_empty", 32'(a_empty), 32'd1);
      chk("a_mrst_ovf",   32'(a_ovf),   32'd0);
      chk("a_mrst_dout",  32'(a_dout),  32'd0);
      a_wr = 1'b1; a_din = 8'h77;
      tick();
      a_wr = 1'b0; a_rd = 1'b1;
      tick();
      a_rd = 1'b0;
      chk("a_mrst_first", 32'(a_dout), 32'h77);

      // B: FWFT, DEPTH=5, interleaved traffic across several pointer wraps.
      b_wr = 1'b1; b_din = 8'hA0;
      tick();
      chk("b_fwft_dout",  32'(b_dout),  32'hA0);
      chk("b_fwft_dv",    32'(b_dv),    32'd1);
      chk("b_fwft_level", 32'(b_level), 32'd1);
      b_din = 8'hA1;
      tick();
      b_din = 8'hA2;
      tick();
      b_rd = 1'b1;
      for (int i = 0; i < 12; i++) begin
         b_din = 8'(32'hA3 + i);
         chk("b_wrap_head", 32'(b_dout), 32'(32'hA0 + i));
         tick();
         chk("b_wrap_level", 32'(b_level), 32'd3);
      end
      b_wr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("b_tail_head", 32'(b_dout), 32'(32'hAC + i));
         tick();
      end
      b_rd = 1'b0;
      chk("b_end_empty", 32'(b_empty), 32'd1);
      chk("b_end_dout",  32'(b_dout),  32'd0);
      chk("b_end_dv",    32'(b_dv),    32'd0);
      chk("b_end_unf",   32'(b_unf),   32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
